// File: rtl/adv7513_init_sequencer.sv
// Walks the ADV7513 configuration ROM and issues each entry as an I2C register write.
// Supports ms delays, END markers, NACK retries and restart requests from hot-plug.
module adv7513_init_sequencer #(
    parameter int unsigned CLK_FREQ_HZ  = 50000000,
    parameter logic [6:0]  I2C_DEV_ADDR = 7'h39,
    parameter int unsigned MAX_RETRY    = 3,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        i2c_req,
    input  logic        i2c_ack,
    output logic [6:0]  i2c_dev,
    output logic [7:0]  i2c_reg,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_addr
);

    localparam int unsigned TICK_CYCLES = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StReq,
        StWait,
        StDelay,
        StAdvance,
        StDone,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [7:0]      err_addr_q, err_addr_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [7:0]      ms_q, ms_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            pend_q, pend_d;
    logic            first_q, first_d;
    logic            xfer_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= 8'd0;
            reg_q      <= 8'd0;
            wdata_q    <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= 8'd0;
            retry_q    <= '0;
            ms_q       <= 8'd0;
            presc_q    <= '0;
            pend_q     <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            retry_q    <= retry_d;
            ms_q       <= ms_d;
            presc_q    <= presc_d;
            pend_q     <= pend_d;
            first_q    <= first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        retry_d    = retry_q;
        ms_d       = ms_q;
        presc_d    = presc_q;
        pend_d     = pend_q;
        first_d    = 1'b0;
        xfer_done  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start || (AUTO_START && first_q)) begin
                    addr_d  = 8'd0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (rom_data == 16'hFFFF) begin
                    state_d = StDone;
                end else if (rom_data[15:8] == 8'hFE) begin
                    if (rom_data[7:0] == 8'd0) begin
                        state_d = StAdvance;
                    end else begin
                        ms_d    = rom_data[7:0];
                        presc_d = '0;
                        state_d = StDelay;
                    end
                end else begin
                    reg_d   = rom_data[15:8];
                    wdata_d = rom_data[7:0];
                    retry_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (start) pend_d = 1'b1;
                if (i2c_ack) begin
                    state_d   = StWait;
                    // Completion may coincide with the accept.
                    xfer_done = i2c_done;
                end
            end
            StWait: begin
                if (start) pend_d = 1'b1;
                xfer_done = i2c_done;
            end
            StDelay: begin
                if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    ms_d    = ms_q - 8'd1;
                    if (ms_q == 8'd1) state_d = StAdvance;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StAdvance: begin
                if (addr_q == 8'hFF) begin
                    err_addr_d = 8'hFF;
                    state_d    = StError;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StError: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A pending restart wins over retrying once the in-flight transfer has finished.
        if (xfer_done) begin
            if (pend_q || start) begin
                addr_d  = 8'd0;
                pend_d  = 1'b0;
                state_d = StFetch;
            end else if (!i2c_nack) begin
                state_d = StAdvance;
            end else if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = StReq;
            end else begin
                err_addr_d = addr_q;
                state_d    = StError;
            end
        end
    end

    assign rom_addr  = addr_q;
    assign i2c_req   = (state_q == StReq);
    assign i2c_dev   = I2C_DEV_ADDR;
    assign i2c_reg   = reg_q;
    assign i2c_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_adv7513_init_sequencer.sv
// Randomised bench for adv7513_init_sequencer: behavioural I2C master and ROM, plus a
// ROM-walking reference model that predicts the write stream and final status.
module tb_adv7513_init_sequencer;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int          TICK      = 1;
    localparam int          MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        i2c_req;
    logic        i2c_ack = 1'b0;
    logic [6:0]  i2c_dev;
    logic [7:0]  i2c_reg;
    logic [7:0]  i2c_wdata;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  err_addr;

    adv7513_init_sequencer #(
        .CLK_FREQ_HZ (CLK_HZ),
        .I2C_DEV_ADDR(7'h39),
        .MAX_RETRY   (MAX_RETRY),
        .AUTO_START  (1'b1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .i2c_req  (i2c_req),
        .i2c_ack  (i2c_ack),
        .i2c_dev  (i2c_dev),
        .i2c_reg  (i2c_reg),
        .i2c_wdata(i2c_wdata),
        .i2c_done (i2c_done),
        .i2c_nack (i2c_nack),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int errors = 0;
    int checks = 0;

    // Master behaviour knobs and observed write attempts.
    int          ack_lat = 2;
    int          done_lat = 10;
    logic [15:0] t_word = 16'h0000;
    int          t_k = 0;
    int          t_cnt = 0;
    logic [15:0] wr_q[$];
    int          m_phase = 0;
    int          m_cnt = 0;
    logic        m_nack = 1'b0;
    int          rom_max = 0;

    // Reference model results.
    logic [15:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;
    logic [7:0]  exp_err_addr;
    int          exp_cycles;

    initial begin : master
        forever begin
            @(negedge clk);
            i2c_ack  = 1'b0;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (!reset_n) begin
                m_phase = 0;
            end else if (m_phase == 2) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = m_nack;
                    m_phase  = 0;
                end
            end else begin
                if (m_phase == 0 && i2c_req) begin
                    m_phase = 1;
                    m_cnt   = ack_lat;
                end
                if (m_phase == 1) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        i2c_ack = 1'b1;
                        wr_q.push_back({i2c_reg, i2c_wdata});
                        m_nack = ({i2c_reg, i2c_wdata} == t_word) && (t_cnt < t_k);
                        if (m_nack) t_cnt++;
                        if (done_lat == 0) begin
                            i2c_done = 1'b1;
                            i2c_nack = m_nack;
                            m_phase  = 0;
                        end else begin
                            m_phase = 2;
                            m_cnt   = done_lat;
                        end
                    end
                end
            end
        end
    end

    initial begin : addr_monitor
        forever begin
            @(negedge clk);
            if (busy && int'(rom_addr) > rom_max) rom_max = int'(rom_addr);
        end
    end

    task automatic model_run();
        int          addr;
        int          pool;
        bit          fin;
        bit          nk;
        logic [15:0] w;
        exp_q.delete();
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = 8'h00;
        exp_cycles   = 1;
        addr = 0;
        pool = t_k;
        fin  = 1'b0;
        while (!fin) begin
            w = rom[addr];
            if (w == 16'hFFFF) begin
                exp_cycles += 3;
                exp_done = 1'b1;
                fin = 1'b1;
            end else begin
                if (w[15:8] == 8'hFE) begin
                    exp_cycles += 3 + int'(w[7:0]) * TICK;
                end else begin
                    for (int a = 0; a <= MAX_RETRY; a++) begin
                        exp_q.push_back(w);
                        nk = (w == t_word) && (pool > 0);
                        if (nk) pool--;
                        if (!nk) break;
                        if (a == MAX_RETRY) begin
                            exp_err      = 1'b1;
                            exp_err_addr = addr[7:0];
                            fin          = 1'b1;
                        end
                    end
                end
                if (!fin) begin
                    if (addr == 255) begin
                        exp_err      = 1'b1;
                        exp_err_addr = 8'hFF;
                        fin          = 1'b1;
                    end else begin
                        addr++;
                    end
                end
            end
        end
    endtask

    function automatic int write_diffs();
        int n;
        n = (wr_q.size() > exp_q.size()) ? wr_q.size() - exp_q.size()
                                         : exp_q.size() - wr_q.size();
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
            if (wr_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic rom_fill_end();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    function automatic logic [15:0] rand_write();
        logic [15:0] w;
        do begin
            w = 16'($urandom);
        end while (w[15:8] == 8'hFE || w == 16'hFFFF);
        return w;
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok  = 1'b1;
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic go(output bit ok, output int cyc);
        wr_q.delete();
        t_cnt   = 0;
        rom_max = 0;
        pulse_start();
        wait_end(6000, ok, cyc);
    endtask

    task automatic load_rom1();
        rom_fill_end();
        rom[0] = 16'h4110;
        rom[1] = 16'h9803;
        rom[2] = 16'hFFFF;
    endtask

    task automatic test_reset();
        bit ok;
        int cyc;
        load_rom1();
        ack_lat  = 2;
        done_lat = 10;
        t_k      = 0;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, i2c_req} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, i2c_req});
        end
        checks++;
        if ({rom_addr, i2c_reg, i2c_wdata, err_addr} !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 0",
                     {rom_addr, i2c_reg, i2c_wdata, err_addr});
        end
        checks++;
        if (i2c_dev !== 7'h39) begin
            errors++;
            $display("FAIL dev_addr: got %h expected 39", i2c_dev);
        end
        wr_q.delete();
        t_cnt = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_end(2000, ok, cyc);
        model_run();
        checks++;
        if (!ok || done !== 1'b1) begin
            errors++;
            $display("FAIL autostart_done: got done=%b expected 1", done);
        end
        checks++;
        if (write_diffs() !== 0) begin
            errors++;
            $display("FAIL autostart_writes: got %0d diffs expected 0", write_diffs());
        end
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        load_rom1();
        ack_lat  = 2;
        done_lat = 10;
        t_k      = 0;
        model_run();
        go(ok, cyc);
        checks++;
        if (wr_q.size() !== 2 || write_diffs() !== 0) begin
            errors++;
            $display("FAIL basic_writes: got %0d writes expected 2 matching", wr_q.size());
        end
        checks++;
        if (!ok || {done, busy, error} !== 3'b100) begin
            errors++;
            $display("FAIL basic_status: got done/busy/error=%b expected 100",
                     {done, busy, error});
        end
        checks++;
        if (rom_max > 2) begin
            errors++;
            $display("FAIL basic_rom_addr: got max %0d expected <= 2", rom_max);
        end
    endtask

    task automatic test_delay();
        bit ok;
        int cyc;
        rom_fill_end();
        rom[0] = 16'hFE05;
        t_k = 0;
        model_run();
        go(ok, cyc);
        checks++;
        if (wr_q.size() !== 0) begin
            errors++;
            $display("FAIL delay_no_req: got %0d requests expected 0", wr_q.size());
        end
        checks++;
        if (!ok || done !== 1'b1 || cyc !== exp_cycles) begin
            errors++;
            $display("FAIL delay5_timing: got %0d cycles expected %0d", cyc, exp_cycles);
        end
        rom[0] = 16'hFE00;
        model_run();
        go(ok, cyc);
        checks++;
        if (!ok || done !== 1'b1 || cyc !== exp_cycles) begin
            errors++;
            $display("FAIL delay0_timing: got %0d cycles expected %0d", cyc, exp_cycles);
        end
    endtask

    task automatic test_nack_all();
        bit ok;
        int cyc;
        int n;
        rom_fill_end();
        rom[0]   = 16'h4110;
        rom[1]   = 16'h9803;
        rom[2]   = 16'h2233;
        ack_lat  = 2;
        done_lat = 4;
        t_word   = 16'h9803;
        t_k      = 100;
        model_run();
        go(ok, cyc);
        checks++;
        if (write_diffs() !== 0 || wr_q.size() !== 5) begin
            errors++;
            $display("FAIL nack_all_reqs: got %0d requests expected %0d", wr_q.size(),
                     exp_q.size());
        end
        checks++;
        if (!ok || {error, done, busy} !== 3'b100 || err_addr !== exp_err_addr) begin
            errors++;
            $display("FAIL nack_all_status: got err/done/busy=%b addr=%h expected 100 addr=%h",
                     {error, done, busy}, err_addr, exp_err_addr);
        end
        n = wr_q.size();
        repeat (30) @(negedge clk);
        checks++;
        if (wr_q.size() !== n || i2c_req !== 1'b0) begin
            errors++;
            $display("FAIL nack_all_quiet: got %0d requests expected %0d", wr_q.size(), n);
        end
    endtask

    task automatic test_nack_once();
        bit ok;
        int cyc;
        t_word = 16'h9803;
        t_k    = 1;
        model_run();
        go(ok, cyc);
        checks++;
        if (write_diffs() !== 0 || wr_q.size() !== 4) begin
            errors++;
            $display("FAIL nack_once_reqs: got %0d requests expected 4", wr_q.size());
        end
        checks++;
        if (!ok || {done, error} !== 2'b10) begin
            errors++;
            $display("FAIL nack_once_status: got done/error=%b expected 10", {done, error});
        end
    endtask

    task automatic test_no_end();
        bit ok;
        int cyc;
        for (int i = 0; i < 256; i++) rom[i] = rand_write();
        ack_lat  = 1;
        done_lat = 0;
        t_k      = 0;
        model_run();
        go(ok, cyc);
        checks++;
        if (wr_q.size() !== 256 || write_diffs() !== 0) begin
            errors++;
            $display("FAIL no_end_writes: got %0d writes expected 256", wr_q.size());
        end
        checks++;
        if (!ok || error !== 1'b1 || err_addr !== 8'hFF) begin
            errors++;
            $display("FAIL no_end_error: got error=%b addr=%h expected 1 ff", error, err_addr);
        end
    endtask

    task automatic test_random();
        bit ok;
        int cyc;
        int n;
        for (int it = 0; it < 8; it++) begin
            rom_fill_end();
            n = 1 + int'($urandom_range(11));
            for (int i = 0; i < n; i++)
                rom[i] = ($urandom_range(3) == 0) ? {8'hFE, 8'($urandom_range(3))} : rand_write();
            t_word   = rom[$urandom_range(n - 1)];
            t_k      = int'($urandom_range(5));
            ack_lat  = 1 + int'($urandom_range(2));
            done_lat = int'($urandom_range(4));
            model_run();
            go(ok, cyc);
            checks++;
            if (write_diffs() !== 0) begin
                errors++;
                $display("FAIL random_writes[%0d]: got %0d writes expected %0d", it,
                         wr_q.size(), exp_q.size());
            end
            checks++;
            if (!ok || done !== exp_done || error !== exp_err ||
                (exp_err && err_addr !== exp_err_addr)) begin
                errors++;
                $display("FAIL random_status[%0d]: got d/e/a=%b/%b/%h expected %b/%b/%h", it,
                         done, error, err_addr, exp_done, exp_err, exp_err_addr);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int cyc;
        load_rom1();
        ack_lat  = 2;
        done_lat = 20;
        t_k      = 0;
        wr_q.delete();
        pulse_start();
        for (int i = 0; i < 100 && wr_q.size() == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_q.size() !== 1) begin
            errors++;
            $display("FAIL mid_wait_setup: got busy=%b acks=%0d expected 1 1", busy, wr_q.size());
        end
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, i2c_req, done, error} !== 4'b0000 ||
            {rom_addr, i2c_reg, i2c_wdata, err_addr} !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b regs=%h expected 0",
                     {busy, i2c_req, done, error}, {rom_addr, i2c_reg, i2c_wdata, err_addr});
        end
        repeat (2) @(negedge clk);
        wr_q.delete();
        t_cnt = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_end(2000, ok, cyc);
        model_run();
        checks++;
        if (!ok || done !== 1'b1 || write_diffs() !== 0) begin
            errors++;
            $display("FAIL reset_restart: got done=%b diffs=%0d expected 1 0", done,
                     write_diffs());
        end
    endtask

    task automatic test_start_mid_wait();
        bit ok;
        int cyc;
        load_rom1();
        ack_lat  = 2;
        done_lat = 10;
        t_k      = 0;
        wr_q.delete();
        t_cnt = 0;
        pulse_start();
        for (int i = 0; i < 100 && wr_q.size() == 0; i++) @(negedge clk);
        pulse_start();
        wait_end(2000, ok, cyc);
        model_run();
        exp_q.push_front(rom[0]);
        checks++;
        if (wr_q.size() < 2 || wr_q[1] !== rom[0]) begin
            errors++;
            $display("FAIL restart_entry0: got %0d writes second=%h expected second=%h",
                     wr_q.size(), (wr_q.size() > 1) ? wr_q[1] : 16'h0, rom[0]);
        end
        checks++;
        if (!ok || done !== 1'b1 || write_diffs() !== 0) begin
            errors++;
            $display("FAIL restart_stream: got done=%b diffs=%0d expected 1 0", done,
                     write_diffs());
        end
    endtask

    initial begin
        rom_fill_end();
        test_reset();
        test_basic();
        test_delay();
        test_nack_all();
        test_nack_once();
        test_no_end();
        test_random();
        test_reset_mid_wait();
        test_start_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
